// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time program loader: FSM states, header
// length width and the byte-lane geometry of an instruction word.
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN0,
        ST_LEN1,
        ST_DATA,
        ST_CSUM,
        ST_DONE
    } loader_state_e;

    localparam int LOADER_LEN_W          = 16;
    localparam int LOADER_BYTES_PER_WORD = 4;
    localparam int LOADER_IDX_W          = $clog2(LOADER_BYTES_PER_WORD);

endpackage

// File: rtl/word_packer.sv
// Packs accepted stream bytes little-endian into 32-bit words and issues a
// registered one-cycle write strobe together with the completed word.
module word_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        accept_i,
    input  logic [7:0]  byte_i,
    output logic        last_byte_o,
    output logic        we_o,
    output logic [31:0] data_o
);

    logic [LOADER_IDX_W-1:0] idx_q, idx_d;
    logic [23:0]             buf_q, buf_d;
    logic [31:0]             data_q, data_d;
    logic                    we_q, we_d;

    assign last_byte_o = (idx_q == LOADER_IDX_W'(LOADER_BYTES_PER_WORD - 1));

    always_comb begin
        idx_d  = idx_q;
        buf_d  = buf_q;
        data_d = data_q;
        we_d   = 1'b0;
        if (clear_i) begin
            idx_d = '0;
        end else if (accept_i) begin
            // The top byte bypasses the staging buffer so the word is ready one edge later.
            if (last_byte_o) begin
                data_d = {byte_i, buf_q};
                we_d   = 1'b1;
            end else begin
                buf_d[{idx_q, 3'b000} +: 8] = byte_i;
            end
            idx_d = idx_q + LOADER_IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q  <= '0;
            buf_q  <= '0;
            data_q <= '0;
            we_q   <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            buf_q  <= buf_d;
            data_q <= data_d;
            we_q   <= we_d;
        end
    end

    assign we_o   = we_q;
    assign data_o = data_q;

endmodule

// File: rtl/program_loader.sv
// Boot loader: parses a 2-byte length header, streams words into instruction
// memory and holds the core until done. Define LOADER_CHECKSUM_EN to add a
// trailing modulo-256 checksum byte.
module program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [7:0]        byte_i,
    input  logic              byte_valid_i,
    output logic              byte_ready_o,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_data_o,
    output logic              core_hold_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    loader_state_e           state_q, state_d;
    logic [7:0]              len_lo_q, len_lo_d;
    logic [LOADER_LEN_W-1:0] len_q, len_d;
    logic [LOADER_LEN_W-1:0] words_q, words_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic                    active_q, active_d;
    logic                    hold_q, hold_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic                    clear;
    logic                    accept;
    logic                    last_byte;
    logic [LOADER_LEN_W-1:0] len_next;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]              sum_q, sum_d;
`endif

    assign accept   = byte_valid_i && active_q;
    assign len_next = {byte_i, len_lo_q};

    word_packer u_packer (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (clear),
        .accept_i    (accept && (state_q == ST_DATA)),
        .byte_i      (byte_i),
        .last_byte_o (last_byte),
        .we_o        (imem_we_o),
        .data_o      (imem_data_o)
    );

    always_comb begin
        state_d  = state_q;
        len_lo_d = len_lo_q;
        len_d    = len_q;
        words_d  = words_q;
        addr_d   = imem_we_o ? addr_q + ADDR_W'(1) : addr_q;
        done_d   = done_q;
        err_d    = err_q;
        clear    = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        sum_d    = sum_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_d = ST_LEN0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    addr_d  = '0;
                    words_d = '0;
                    clear   = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            ST_LEN0: begin
                if (accept) begin
                    len_lo_d = byte_i;
                    state_d  = ST_LEN1;
                end
            end
            ST_LEN1: begin
                if (accept) begin
                    len_d = len_next;
                    if (len_next == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else if (len_next > LOADER_LEN_W'(MAX_WORDS)) begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
`ifdef LOADER_CHECKSUM_EN
                    sum_d = sum_q + byte_i;
`endif
                    if (last_byte) begin
                        words_d = words_q + LOADER_LEN_W'(1);
                        if (words_q == len_q - LOADER_LEN_W'(1)) begin
`ifdef LOADER_CHECKSUM_EN
                            state_d = ST_CSUM;
`else
                            state_d = ST_DONE;
                            done_d  = 1'b1;
`endif
                        end
                    end
                end
            end
            ST_CSUM: begin
`ifdef LOADER_CHECKSUM_EN
                if (accept) begin
                    state_d = ST_DONE;
                    if (byte_i == sum_q) done_d = 1'b1;
                    else                 err_d  = 1'b1;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Ready/busy come from the next state so they are registered yet aligned with it.
    assign active_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
    assign hold_d   = !((state_q == ST_DONE) && (state_d == ST_DONE) && !err_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            len_lo_q <= '0;
            len_q    <= '0;
            words_q  <= '0;
            addr_q   <= '0;
            active_q <= 1'b0;
            hold_q   <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            len_lo_q <= len_lo_d;
            len_q    <= len_d;
            words_q  <= words_d;
            addr_q   <= addr_d;
            active_q <= active_d;
            hold_q   <= hold_d;
            done_q   <= done_d;
            err_q    <= err_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q    <= sum_d;
`endif
        end
    end

    assign byte_ready_o = active_q;
    assign busy_o       = active_q;
    assign imem_addr_o  = addr_q;
    assign core_hold_o  = hold_q;
    assign done_o       = done_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Randomized self-checking bench for program_loader; expected writes and
// status come from a byte-list model of the image format.
module tb_program_loader;

    localparam int ADDR_W    = 8;
    localparam int MAX_WORDS = 256;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start_i = 1'b0;
    logic [7:0]        byte_i = '0;
    logic              byte_valid_i = 1'b0;
    logic              byte_ready_o;
    logic              imem_we_o;
    logic [ADDR_W-1:0] imem_addr_o;
    logic [31:0]       imem_data_o;
    logic              core_hold_o;
    logic              busy_o;
    logic              done_o;
    logic              err_o;

    program_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .byte_i       (byte_i),
        .byte_valid_i (byte_valid_i),
        .byte_ready_o (byte_ready_o),
        .imem_we_o    (imem_we_o),
        .imem_addr_o  (imem_addr_o),
        .imem_data_o  (imem_data_o),
        .core_hold_o  (core_hold_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        int unsigned       cyc;
    } wr_t;

    wr_t got_q[$];
    wr_t exp_q[$];

    always @(negedge clk) begin
        if (imem_we_o) begin
            wr_t g;
            g.addr = imem_addr_o;
            g.data = imem_data_o;
            g.cyc  = cyc;
            got_q.push_back(g);
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_ready"}, 32'(byte_ready_o), 32'd0);
        check({pfx, "_we"},    32'(imem_we_o),    32'd0);
        check({pfx, "_addr"},  32'(imem_addr_o),  32'd0);
        check({pfx, "_data"},  imem_data_o,       32'd0);
        check({pfx, "_hold"},  32'(core_hold_o),  32'd1);
        check({pfx, "_busy"},  32'(busy_o),       32'd0);
        check({pfx, "_done"},  32'(done_o),       32'd0);
        check({pfx, "_err"},   32'(err_o),        32'd0);
    endtask

    // Offers one byte; returns the cycle stamp of the accepting edge.
    task automatic send_byte(input logic [7:0] b, input bit gappy, output int unsigned acc_cyc);
        int unsigned budget = 0;
        if (gappy) begin
            @(negedge clk);
            byte_valid_i = 1'b0;
        end
        @(negedge clk);
        byte_valid_i = 1'b1;
        byte_i       = b;
        while (!byte_ready_o && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (!byte_ready_o) begin
            check("ready_timeout", 32'(byte_ready_o), 32'd1);
            byte_valid_i = 1'b0;
            acc_cyc = 0;
            return;
        end
        @(posedge clk);
        #1;
        acc_cyc = cyc;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic load(input logic [7:0] s[$], input bit gappy, input bit bad_csum);
        logic [15:0] len;
        int unsigned nw;
        bit          e_err;
        bit          e_done;
        logic [7:0]  sum;
        int unsigned acc;
        int unsigned budget;
        wr_t         e;
        len    = {s[1], s[0]};
        e_err  = (len > 16'(MAX_WORDS));
        e_done = !e_err;
        nw     = e_err ? 0 : int'(len);
        sum    = '0;
        exp_q.delete();
        got_q.delete();
        pulse_start();
        send_byte(s[0], gappy, acc);
        send_byte(s[1], gappy, acc);
        for (int k = 0; k < 4 * int'(nw); k++) begin
            send_byte(s[2 + k], gappy, acc);
            sum = sum + s[2 + k];
            if (k % 4 == 3) begin
                e.addr = ADDR_W'(k / 4);
                e.data = {s[k + 2], s[k + 1], s[k], s[k - 1]};
                e.cyc  = acc;
                exp_q.push_back(e);
            end
        end
        if (CSUM_ON && nw > 0) begin
            send_byte(bad_csum ? sum + 8'd1 : sum, gappy, acc);
            if (bad_csum) begin
                e_err  = 1'b1;
                e_done = 1'b0;
            end
        end
        @(negedge clk);
        byte_valid_i = 1'b0;
        budget = 0;
        while (!(done_o || err_o) && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        check("done_latency", budget, 0);
        check("done",         32'(done_o),       32'(e_done));
        check("err",          32'(err_o),        32'(e_err));
        check("busy_done",    32'(busy_o),       32'd0);
        check("ready_done",   32'(byte_ready_o), 32'd0);
        check("hold_entry",   32'(core_hold_o),  32'd1);
        @(negedge clk);
        check("hold_after",   32'(core_hold_o),  32'(e_err));
        @(negedge clk);
        check("wr_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check("wr_addr", 32'(got_q[i].addr), 32'(exp_q[i].addr));
            check("wr_data", got_q[i].data,      exp_q[i].data);
            check("wr_cyc",  got_q[i].cyc,       exp_q[i].cyc);
        end
    endtask

    logic [7:0] img_a[$];
    logic [7:0] s[$];

    initial begin
        int unsigned acc;
        int unsigned len;
        img_a = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};

        #2 rst = 1'b0;
        #1 check_reset_values("por");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        check("idle_ready", 32'(byte_ready_o), 32'd0);

        load(img_a, 1'b0, 1'b0);
        s = '{8'h00, 8'h00};
        load(s, 1'b0, 1'b0);
        s = '{8'h01, 8'h01};
        load(s, 1'b0, 1'b0);
        load(img_a, 1'b1, 1'b0);

        // Reset in the middle of the second word.
        pulse_start();
        for (int i = 0; i < 8; i++) send_byte(img_a[i], 1'b0, acc);
        @(negedge clk);
        rst = 1'b0;
        byte_valid_i = 1'b0;
        #1 check_reset_values("midrst");
        @(negedge clk);
        rst = 1'b1;
        load(img_a, 1'b0, 1'b0);

        if (CSUM_ON) begin
            s = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
            load(s, 1'b0, 1'b0);
            load(s, 1'b0, 1'b1);
        end

        // Largest legal image.
        s = '{8'h00, 8'h01};
        for (int i = 0; i < 4 * MAX_WORDS; i++) s.push_back(8'($urandom));
        load(s, 1'b0, 1'b0);

        for (int t = 0; t < 10; t++) begin
            len = ($urandom_range(0, 7) == 0) ? $urandom_range(257, 1000) : $urandom_range(0, 6);
            s = '{};
            s.push_back(8'(len));
            s.push_back(8'(len >> 8));
            if (len <= MAX_WORDS)
                for (int i = 0; i < 4 * int'(len); i++) s.push_back(8'($urandom));
            load(s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
